// File: rtl/switch_code_capture.sv
// Conditions four raw active-low switches into single-cycle codes for the game FSM.
// Two-flop synchroniser, debounce, and a capture FSM that emits one code per press/release.
module switch_code_capture #(
   parameter int         DEBOUNCE_CYCLES = 16,
   parameter int         CNT_W           = 10,
   parameter int         HOLD_MAX        = 1023,
   parameter logic [3:0] IDLE_CODE       = 4'b1111
) (
   input  logic       clk,
   input  logic       enable,
   input  logic [3:0] sw_raw,
   output logic [3:0] change,
   output logic       press_pending,
   output logic       stuck
);

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      EMIT,
      STUCK
   } state_t;

   localparam logic [CNT_W-1:0] DB_MAX    = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] DB_LOAD   = CNT_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   logic [3:0]       sync_meta;
   logic [3:0]       sw_sync;
   logic [3:0]       sw_prev;
   logic [3:0]       sw_stable;
   logic [CNT_W-1:0] db_cnt;
   logic             sample_changed;

   state_t           state, state_next;
   logic [3:0]       code, code_next;
   logic [CNT_W-1:0] hold_cnt, hold_next;
   logic [3:0]       change_next;

   assign sample_changed = (sw_sync != sw_prev);

   // sw_stable updates on the edge where the run of matching samples reaches DEBOUNCE_CYCLES-1
   always_ff @(posedge clk) begin
      if (!enable) begin
         sync_meta <= IDLE_CODE;
         sw_sync   <= IDLE_CODE;
         sw_prev   <= IDLE_CODE;
         sw_stable <= IDLE_CODE;
         db_cnt    <= '0;
      end else begin
         sync_meta <= sw_raw;
         sw_sync   <= sync_meta;
         sw_prev   <= sw_sync;
         if (sample_changed) begin
            db_cnt <= '0;
         end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + CNT_W'(1);
         end
         if (!sample_changed && (db_cnt == DB_LOAD)) begin
            sw_stable <= sw_sync;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!enable) begin
         state    <= IDLE;
         code     <= IDLE_CODE;
         hold_cnt <= '0;
         change   <= IDLE_CODE;
      end else begin
         state    <= state_next;
         code     <= code_next;
         hold_cnt <= hold_next;
         change   <= change_next;
      end
   end

   // Release wins over the stuck check; a changed pattern replaces the captured code
   always_comb begin
      state_next = state;
      code_next  = code;
      hold_next  = hold_cnt;
      case (state)
         IDLE: begin
            if (sw_stable != IDLE_CODE) begin
               code_next  = sw_stable;
               hold_next  = '0;
               state_next = PRESSED;
            end
         end
         PRESSED: begin
            if (sw_stable == IDLE_CODE) begin
               state_next = EMIT;
            end else if (sw_stable != code) begin
               code_next = sw_stable;
            end else if (hold_cnt == HOLD_LAST) begin
               state_next = STUCK;
            end else begin
               hold_next = hold_cnt + CNT_W'(1);
            end
         end
         EMIT: begin
            state_next = IDLE;
         end
         STUCK: begin
            if (sw_stable == IDLE_CODE) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      change_next = (state_next == EMIT) ? code : IDLE_CODE;
   end

   assign press_pending = (state == PRESSED);
   assign stuck         = (state == STUCK);

endmodule
